// File: rtl/z_core_alu_pkg.sv
// Shared definitions for the sequenced ALU-control decoder: RV32 opcode and
// funct fields, the extended operation codes, execution-unit and FSM state types.
// No ports; the decoder, the sequencer and the interface import this package.
package z_core_alu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [4:0] INST_ADD     = 5'd0;
  localparam logic [4:0] INST_SUB     = 5'd1;
  localparam logic [4:0] INST_SLL     = 5'd2;
  localparam logic [4:0] INST_SLT     = 5'd3;
  localparam logic [4:0] INST_SLTU    = 5'd4;
  localparam logic [4:0] INST_XOR     = 5'd5;
  localparam logic [4:0] INST_SRL     = 5'd6;
  localparam logic [4:0] INST_SRA     = 5'd7;
  localparam logic [4:0] INST_OR      = 5'd8;
  localparam logic [4:0] INST_AND     = 5'd9;
  localparam logic [4:0] INST_BEQ     = 5'd10;
  localparam logic [4:0] INST_BNE     = 5'd11;
  localparam logic [4:0] INST_BLT     = 5'd12;
  localparam logic [4:0] INST_BGE     = 5'd13;
  localparam logic [4:0] INST_BLTU    = 5'd14;
  localparam logic [4:0] INST_BGEU    = 5'd15;
  localparam logic [4:0] INST_MUL     = 5'd16;
  localparam logic [4:0] INST_MULH    = 5'd17;
  localparam logic [4:0] INST_MULHSU  = 5'd18;
  localparam logic [4:0] INST_MULHU   = 5'd19;
  localparam logic [4:0] INST_DIV     = 5'd20;
  localparam logic [4:0] INST_DIVU    = 5'd21;
  localparam logic [4:0] INST_REM     = 5'd22;
  localparam logic [4:0] INST_REMU    = 5'd23;
  localparam logic [4:0] INST_ILLEGAL = 5'd31;

  // Latency counter sized for the largest legal MUL/DIV latency (64).
  localparam int CNT_W = $clog2(64 + 1);

  typedef enum logic [1:0] {
    UNIT_ALU = 2'd0,
    UNIT_MUL = 2'd1,
    UNIT_DIV = 2'd2
  } alu_unit_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // funct3 -> operation for register/immediate arithmetic with base funct7.
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      F3_ADD:  return INST_ADD;
      F3_SLL:  return INST_SLL;
      F3_SLT:  return INST_SLT;
      F3_SLTU: return INST_SLTU;
      F3_XOR:  return INST_XOR;
      F3_SR:   return INST_SRL;
      F3_OR:   return INST_OR;
      default: return INST_AND;
    endcase
  endfunction

endpackage

// File: rtl/z_core_alu_seq_ctrl_if.sv
// Decode-side and execute-side handshake bundle of the sequenced ALU-control decoder.
//   in_valid/in_ready, alu_op/alu_funct3/alu_funct7 : instruction from decode
//   out_valid/out_ready, alu_inst_type/alu_unit/illegal : result to execute
//   busy : a multi-cycle op is in flight
// master = decode/execute side, slave = the sequencer.
interface z_core_alu_seq_ctrl_if #(
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      alu_op;
  logic [2:0]      alu_funct3;
  logic [6:0]      alu_funct7;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] alu_inst_type;
  logic [1:0]      alu_unit;
  logic            illegal;
  logic            busy;

  modport master (
    output in_valid, alu_op, alu_funct3, alu_funct7, out_ready,
    input  in_ready, out_valid, alu_inst_type, alu_unit, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, alu_funct3, alu_funct7, out_ready,
    output in_ready, out_valid, alu_inst_type, alu_unit, illegal, busy
  );
endinterface

// File: rtl/z_core_alu_decode.sv
// Combinational RV32I/RV32M decoder into the extended ALU operation code.
//   alu_op_i, funct3_i, funct7_i : instruction fields
//   inst_type_o : operation code (INST_ILLEGAL for any rejected encoding)
//   unit_o      : execution unit (ALU for illegal encodings)
//   illegal_o   : encoding rejected
module z_core_alu_decode
  import z_core_alu_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output logic [4:0] inst_type_o,
  output alu_unit_e  unit_o,
  output logic       illegal_o
);

  logic [4:0] inst;
  alu_unit_e  unit;
  logic       ill;

  always_comb begin
    inst = INST_ADD;
    unit = UNIT_ALU;
    ill  = 1'b0;
    case (alu_op_i)
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: inst = INST_ADD;
      OPC_OP: begin
        case (funct7_i)
          F7_BASE: inst = base_op(funct3_i);
          F7_ALT: begin
            if (funct3_i == F3_ADD)     inst = INST_SUB;
            else if (funct3_i == F3_SR) inst = INST_SRA;
            else                        ill  = 1'b1;
          end
          F7_MULDIV: begin
            if (ENABLE_M) begin
              inst = INST_MUL + {2'b00, funct3_i};
              // funct3[2] splits the M extension into multiply and divide halves.
              unit = funct3_i[2] ? UNIT_DIV : UNIT_MUL;
            end else begin
              ill = 1'b1;
            end
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        // funct7 is only an encoding field for shifts; elsewhere it is immediate bits.
        case (funct3_i)
          F3_SLL: begin
            if (funct7_i == F7_BASE) inst = INST_SLL;
            else                     ill  = 1'b1;
          end
          F3_SR: begin
            if (funct7_i == F7_BASE)     inst = INST_SRL;
            else if (funct7_i == F7_ALT) inst = INST_SRA;
            else                         ill  = 1'b1;
          end
          default: inst = base_op(funct3_i);
        endcase
      end
      OPC_BRANCH: begin
        case (funct3_i)
          F3_BEQ:  inst = INST_BEQ;
          F3_BNE:  inst = INST_BNE;
          F3_BLT:  inst = INST_BLT;
          F3_BGE:  inst = INST_BGE;
          F3_BLTU: inst = INST_BLTU;
          F3_BGEU: inst = INST_BGEU;
          default: ill  = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      inst = INST_ILLEGAL;
      unit = UNIT_ALU;
    end
  end

  assign inst_type_o = inst;
  assign unit_o      = unit;
  assign illegal_o   = ill;

endmodule

// File: rtl/z_core_alu_seq_ctrl.sv
// Sequenced ALU-control decoder: decodes an accepted instruction, holds it for
// its unit latency, then presents the registered result to execute.
//   clk, rstn (async, active-low), flush (synchronous, drops everything)
//   bus : slave side of the decode/execute handshake bundle
//
// state | meaning
// IDLE  | nothing held, ready for an instruction
// WAIT  | multi-cycle op in flight, counter counting down to 1
// DONE  | result valid, waiting for execute to consume it
module z_core_alu_seq_ctrl
  import z_core_alu_pkg::*;
#(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32,
  parameter int OP_W       = 5
) (
  input logic                 clk,
  input logic                 rstn,
  input logic                 flush,
  z_core_alu_seq_ctrl_if.slave bus
);

  logic [4:0]      dec_type;
  alu_unit_e       dec_unit;
  logic            dec_ill;
  logic [CNT_W-1:0] lat;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  type_q, type_d;
  alu_unit_e        unit_q, unit_d;
  logic             ill_q, ill_d;
  logic             in_ready;
  logic             accept;

  z_core_alu_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .alu_op_i    (bus.alu_op),
    .funct3_i    (bus.alu_funct3),
    .funct7_i    (bus.alu_funct7),
    .inst_type_o (dec_type),
    .unit_o      (dec_unit),
    .illegal_o   (dec_ill)
  );

  always_comb begin
    case (dec_unit)
      UNIT_MUL: lat = CNT_W'(MUL_CYCLES);
      UNIT_DIV: lat = CNT_W'(DIV_CYCLES);
      default:  lat = CNT_W'(1);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    type_d   = type_q;
    unit_d   = unit_q;
    ill_d    = ill_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      DONE:    in_ready = bus.out_ready;
      default: in_ready = 1'b0;
    endcase
    if (flush) in_ready = 1'b0;
    accept = bus.in_valid && in_ready;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      // Covers both IDLE and the DONE back-to-back case: the held result is
      // consumed on this same edge.
      type_d  = OP_W'(dec_type);
      unit_d  = dec_unit;
      ill_d   = dec_ill;
      cnt_d   = lat - CNT_W'(1);
      state_d = (lat == CNT_W'(1)) ? DONE : WAIT;
    end else begin
      case (state_q)
        WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      unit_q  <= UNIT_ALU;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      unit_q  <= unit_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = (state_q == DONE);
  assign bus.busy          = (state_q == WAIT);
  assign bus.alu_inst_type = type_q;
  assign bus.alu_unit      = unit_q;
  assign bus.illegal       = ill_q;

endmodule
